// File: rtl/systolic_ctrl_if.sv
// rtl/systolic_ctrl_if.sv - weight, activation and result streams of systolic_ctrl
interface systolic_ctrl_if #(
    parameter int N = 4
);
    logic            w_valid;
    logic            w_ready;
    logic [N*8-1:0]  w_data;
    logic            a_valid;
    logic            a_ready;
    logic [N*8-1:0]  a_data;
    logic            r_valid;
    logic [N*32-1:0] r_data;

    modport master (
        output w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready, r_valid, r_data
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready, r_valid, r_data
    );
endinterface

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - weight-stationary systolic array sequencer; SYSTOLIC_CTRL_PERF_EN adds stall_cnt
module systolic_ctrl #(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vec,
    output logic               busy,
    output logic               done,
    systolic_ctrl_if.slave     s_if,
    output logic [N*N*8-1:0]   arr_weight,
    output logic [N*8-1:0]     arr_west,
    input  logic [N*32-1:0]    arr_south
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt
`endif
);
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ROW_W-1:0]  w_row;
    logic [CNT_W-1:0]  vec_left;
    logic [2*N-1:0]    tag_sr;
    logic [N*8-1:0]    skew_in;
    logic [N*32-1:0]   aligned;
    logic              w_fire;
    logic              a_fire;

    assign w_fire  = (state == S_LOAD) && s_if.w_valid;
    assign a_fire  = (state == S_STREAM) && s_if.a_valid;
    assign skew_in = a_fire ? s_if.a_data : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b1;
        done         = 1'b0;
        s_if.w_ready = 1'b0;
        s_if.a_ready = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                s_if.w_ready = 1'b1;
                if (w_fire && (w_row == ROW_W'(N - 1))) begin
                    state_nxt = (vec_left == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                s_if.a_ready = 1'b1;
                if (a_fire && (vec_left == CNT_W'(1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // tag_sr empties on the same edge that raises the final r_valid
                if (tag_sr == '0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_row      <= '0;
            vec_left   <= '0;
            arr_weight <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                w_row    <= '0;
                vec_left <= num_vec;
            end
            if (w_fire) begin
                arr_weight[int'(w_row)*N*8 +: N*8] <= s_if.w_data;
                w_row                              <= w_row + ROW_W'(1);
            end
            if (a_fire) begin
                vec_left <= vec_left - CNT_W'(1);
            end
        end
    end

    // Row i sees its lane after i+1 registers, matching the array's diagonal wavefront
    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [7:0] sr [gi+1];
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int k = 0; k <= gi; k++) begin
                    sr[k] <= '0;
                end
            end else begin
                sr[0] <= skew_in[gi*8 +: 8];
                for (int k = 1; k <= gi; k++) begin
                    sr[k] <= sr[k-1];
                end
            end
        end
        assign arr_west[gi*8 +: 8] = sr[gi];
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_deskew
        if (gj == N - 1) begin : g_pass
            assign aligned[gj*32 +: 32] = arr_south[gj*32 +: 32];
        end else begin : g_dly
            logic [31:0] dr [N-1-gj];
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int k = 0; k < N - 1 - gj; k++) begin
                        dr[k] <= '0;
                    end
                end else begin
                    dr[0] <= arr_south[gj*32 +: 32];
                    for (int k = 1; k < N - 1 - gj; k++) begin
                        dr[k] <= dr[k-1];
                    end
                end
            end
            assign aligned[gj*32 +: 32] = dr[N-2-gj];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_sr       <= '0;
            s_if.r_valid <= 1'b0;
            s_if.r_data  <= '0;
        end else begin
            tag_sr       <= {tag_sr[2*N-2:0], a_fire};
            s_if.r_valid <= tag_sr[2*N-1];
            if (tag_sr[2*N-1]) begin
                s_if.r_data <= aligned;
            end
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_cnt <= '0;
        end else if ((state == S_STREAM) && !s_if.a_valid) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - directed bench for systolic_ctrl with a behavioural PE array
module tb_systolic_ctrl;
    localparam int N     = 4;
    localparam int CNT_W = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [15:0]   num_vec;
    logic          busy;
    logic          done;
    logic [127:0]  arr_weight;
    logic [31:0]   arr_west;
    logic [127:0]  arr_south;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    systolic_ctrl_if #(.N(N)) bus ();

    systolic_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .num_vec    (num_vec),
        .busy       (busy),
        .done       (done),
        .s_if       (bus.slave),
        .arr_weight (arr_weight),
        .arr_west   (arr_west),
`ifdef SYSTOLIC_CTRL_PERF_EN
        .stall_cnt  (stall_cnt),
`endif
        .arr_south  (arr_south)
    );

    always #5 clk = ~clk;

    // PE array: activations move east, partial sums move south, north edge tied to 0
    logic [7:0]         act [4][4];
    logic signed [31:0] ps  [4][4];

    function automatic logic [7:0] ain_f(int i, int j);
        return (j == 0) ? arr_west[i*8 +: 8] : act[i][j-1];
    endfunction

    function automatic logic signed [31:0] pin_f(int i, int j);
        return (i == 0) ? 32'sd0 : ps[i-1][j];
    endfunction

    function automatic logic signed [31:0] prod_f(int i, int j);
        logic signed [31:0] av;
        logic signed [31:0] wv;
        av = $signed({24'b0, ain_f(i, j)});
        wv = $signed({{24{arr_weight[(i*4+j)*8+7]}}, arr_weight[(i*4+j)*8 +: 8]});
        return av * wv;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (!reset_n) begin
                    act[i][j] <= '0;
                    ps[i][j]  <= '0;
                end else begin
                    act[i][j] <= ain_f(i, j);
                    ps[i][j]  <= pin_f(i, j) + prod_f(i, j);
                end
            end
        end
    end

    assign arr_south = {ps[3][3], ps[3][2], ps[3][1], ps[3][0]};

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [127:0]  r_q[$];
    int            r_cyc[$];
    int            acc_cyc[$];
    int            w_acc_cyc[$];
    int            done_cyc[$];
    int            aready_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.r_valid) begin
            r_q.push_back(bus.r_data);
            r_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (bus.a_valid && bus.a_ready) acc_cyc.push_back(cyc);
        if (bus.w_valid && bus.w_ready) w_acc_cyc.push_back(cyc);
        if (bus.a_ready) aready_cnt = aready_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        r_q.delete();
        r_cyc.delete();
        acc_cyc.delete();
        w_acc_cyc.delete();
        done_cyc.delete();
        aready_cnt = 0;
    endtask

    task automatic start_job(input logic [15:0] nv);
        start   = 1'b1;
        num_vec = nv;
        tick();
        start   = 1'b0;
        num_vec = '0;
        chk("busy_rise", busy, 1);
    endtask

    task automatic load_w(input logic [127:0] w);
        for (int i = 0; i < 4; i++) begin
            bus.w_valid = 1'b1;
            bus.w_data  = w[i*32 +: 32];
            chk("w_ready", bus.w_ready, 1);
            tick();
        end
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_data  = d;
        tick();
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done_cyc.size() == 0 && n < bound) begin
            tick();
            n++;
        end
        chk("done_seen", done_cyc.size() != 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_r_valid"}, bus.r_valid, 0);
        chk({tag, "_r_data"}, bus.r_data, 0);
        chk({tag, "_w_ready"}, bus.w_ready, 0);
        chk({tag, "_a_ready"}, bus.a_ready, 0);
        chk({tag, "_arr_weight"}, arr_weight, 0);
        chk({tag, "_arr_west"}, arr_west, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        num_vec     = '0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // identity weights, one vector: latency 2N, done one cycle after r_valid
        clear_mon();
        start_job(16'd1);
        load_w(128'h01000000_00010000_00000100_00000001);
        chk("ident_weight", arr_weight, 128'h01000000_00010000_00000100_00000001);
        drive_a(1'b1, 32'h04030201);
        drive_a(1'b0, 32'hFFFFFFFF);
        wait_done(30);
        chk("ident_nres", r_q.size(), 1);
        chk("ident_r", r_q[0], {32'd4, 32'd3, 32'd2, 32'd1});
        // acceptance sampled the negedge before its edge, hence 2N+1
        chk("ident_latency", r_cyc[0] - acc_cyc[0], 9);
        chk("ident_done_after_r", done_cyc[0] - r_cyc[0], 1);
        chk("ident_busy_fall", busy, 0);

        // signed extremes, started back-to-back in the cycle busy falls
        clear_mon();
        start_job(16'd1);
        load_w({16{8'h80}});
        drive_a(1'b1, 32'hFFFFFFFF);
        drive_a(1'b0, 32'h0);
        wait_done(30);
        chk("neg_nres", r_q.size(), 1);
        chk("neg_r", r_q[0], {4{32'hFFFE0200}});

        clear_mon();
        start_job(16'd1);
        load_w({16{8'h7F}});
        drive_a(1'b1, 32'hFFFFFFFF);
        drive_a(1'b0, 32'h0);
        wait_done(30);
        chk("pos_r", r_q[0], {4{32'h0001FA04}});

        // gapped stream 1,0,1,1 with W[i][0] = i+1
        clear_mon();
        start_job(16'd3);
        load_w({32'h4, 32'h3, 32'h2, 32'h1});
        drive_a(1'b1, 32'h01010101);
        drive_a(1'b0, 32'hFFFFFFFF);
        drive_a(1'b1, 32'h01020304);
        drive_a(1'b1, 32'h000000FF);
        drive_a(1'b0, 32'h0);
        wait_done(40);
        chk("gap_nres", r_q.size(), 3);
        chk("gap_r0", r_q[0], 128'd10);
        chk("gap_r1", r_q[1], 128'd20);
        chk("gap_r2", r_q[2], 128'd255);
        chk("gap_latency", r_cyc[0] - acc_cyc[0], 9);
        chk("gap_space01", r_cyc[1] - r_cyc[0], 2);
        chk("gap_space12", r_cyc[2] - r_cyc[1], 1);
        chk("gap_done", done_cyc[0] - r_cyc[2], 1);
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("gap_stall_cnt", stall_cnt, 1);
`endif

        // empty job: weights only
        clear_mon();
        start_job(16'd0);
        load_w(128'h01000000_00010000_00000100_00000001);
        wait_done(10);
        chk("empty_wbeats", w_acc_cyc.size(), 4);
        chk("empty_done", done_cyc[0] - w_acc_cyc[3], 1);
        chk("empty_nres", r_q.size(), 0);
        chk("empty_aready", aready_cnt, 0);

        // reset after 2 of 5 vectors
        clear_mon();
        start_job(16'd5);
        load_w({16{8'h01}});
        drive_a(1'b1, 32'h01010101);
        drive_a(1'b1, 32'h02020202);
        bus.a_valid = 1'b0;
        reset_n     = 1'b0;
        tick();
        reset_n     = 1'b1;
        chk_all_zero("midrst");
        repeat (14) tick();
        chk("midrst_no_late_r", r_q.size(), 0);
        chk("midrst_idle", busy, 0);

        // stray start and w_valid during STREAM are ignored
        clear_mon();
        start_job(16'd2);
        load_w({4{32'h04FD0201}});
        bus.w_valid = 1'b1;
        bus.w_data  = 32'hDEADBEEF;
        start       = 1'b1;
        num_vec     = 16'd7;
        drive_a(1'b1, 32'h04030201);
        start       = 1'b0;
        num_vec     = '0;
        chk("ign_busy", busy, 1);
        drive_a(1'b1, 32'h0500000A);
        bus.a_valid = 1'b0;
        wait_done(40);
        chk("ign_weight", arr_weight, {4{32'h04FD0201}});
        bus.w_valid = 1'b0;
        repeat (6) tick();
        chk("ign_nres", r_q.size(), 2);
        chk("ign_r0", r_q[0], {32'd40, 32'hFFFFFFE2, 32'd20, 32'd10});
        chk("ign_r1", r_q[1], {32'd60, 32'hFFFFFFD3, 32'd30, 32'd15});
        chk("ign_ndone", done_cyc.size(), 1);
        chk("ign_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for an N×N weight-stationary systolic array of MAC processing elements. Each PE passes 8-bit unsigned activations east and signed 32-bit partial sums south. The block loads and holds the array's weights, feeds activation vectors into the rows with the required diagonal skew, and re-aligns the bottom-row partial sums into whole result vectors. It sits between the stream-side producer/consumer and the PE array, and controls one matrix-vector job per `start`.

## Interface
Parameters:
- `N`, default 4: array dimension (rows = columns); 2..16.
- `CNT_W`, default 16: width of the vector count.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin job; sampled only in IDLE.
- `num_vec`, in, CNT_W: number of activation vectors in the job; latched with `start`.
- `busy`, out, 1: high from the cycle after `start` is accepted through DONE.
- `done`, out, 1: one-cycle pulse in DONE.
- `w_valid`, in, 1 / `w_ready`, out, 1 / `w_data`, in, N*8: weight row beats. Beat i is row i. Lane j (`[8j+:8]`) is the signed weight W[i][j].
- `a_valid`, in, 1 / `a_ready`, out, 1 / `a_data`, in, N*8: activation vectors. Lane i is unsigned a[i], which feeds row i.
- `r_valid`, out, 1 / `r_data`, out, N*32: result vectors. Lane j is signed R[j]. There is no backpressure on results.
- `arr_weight`, out, N*N*8: held weights to the array. Byte index i*N+j is W[i][j].
- `arr_west`, out, N*8: skewed activations into the west edge of rows 0..N-1.
- `arr_south`, in, N*32: `out_south` of bottom-row PEs, lane j = column j.

## Operation
- **Array boundary:** the array's north inputs are tied to 0 outside this block.
- **Result arithmetic:**
  - R[j] = Σ_i a[i]·W[i][j]. Each product is the zero-extended activation times the signed weight.
  - The sum is 32-bit two's complement and wraps; there is no saturation.
- **States:** IDLE → LOAD → STREAM → DRAIN → DONE → IDLE.
- **IDLE:**
  - `w_ready`, `a_ready` and `busy` are 0.
  - `start`=1 latches `num_vec` and moves to LOAD.
- **LOAD:**
  - `w_ready`=1.
  - Accepts exactly N beats (handshake is `w_valid`&&`w_ready`) into `arr_weight` row by row, using a row counter.
  - After the Nth beat: go to STREAM, or to DONE if `num_vec`=0.
- **STREAM:**
  - `a_ready`=1.
  - Each accepted vector enters the skew line with tag=1.
  - Each cycle with no acceptance inserts zeros with tag=0 (a bubble).
  - After the `num_vec`-th acceptance, go to DRAIN.
- **DRAIN:**
  - Zeros are fed into the skew line.
  - Stay until the tag pipeline is empty and the last `r_valid` has been issued, then go to DONE.
- **DONE:**
  - `done`=1 for one cycle.
  - Go to IDLE. `busy` falls with the IDLE entry.
- **Skew:** lane i of an accepted vector reaches `arr_west[i]` i+1 cycles after the accepting edge, through a per-row register chain.
- **De-skew:** column j of `arr_south` is delayed N−1−j extra cycles so that all lanes align. The aligned vector is then registered into `r_data`.
- **Tag pipeline:** a 2N-deep shift register. Its output drives `r_valid`.
- **Weights:** `arr_weight` is held constant from the end of LOAD until the next job's LOAD. Weights never change during STREAM or DRAIN.
- **Ignored inputs:**
  - `start` outside IDLE.
  - `w_valid` outside LOAD.
  - `a_valid` outside STREAM.
- **Reset:** applies at any time, including mid-job.
  - State returns to IDLE.
  - All skew, de-skew and tag registers are cleared. In-flight results are discarded; no `r_valid` is issued for them.
  - `arr_weight` is cleared.

## Timing
- **Reset values:** all outputs are 0. This includes `busy`, `done`, `r_valid`, `r_data`, `w_ready`, `a_ready`, `arr_weight` and `arr_west`.
- **Result latency:** `r_valid` is high exactly 2N cycles after the edge that accepted the vector (8 cycles for N=4).
- **Throughput:** one vector per cycle. Gaps in `a_valid` reproduce as identical gaps in `r_valid`.
- **`done` timing:** `done` is asserted the cycle after the last `r_valid`.
- **`busy` timing:**
  - Rises the cycle after `start`.
  - Falls the cycle after `done`.
- **Back-to-back jobs:** `start` may be asserted in the cycle `busy` falls and is accepted.

## Configuration
- **Macro:** `SYSTOLIC_CTRL_PERF_EN`.
- **Defined:**
  - Adds output `stall_cnt` [CNT_W-1:0], which counts STREAM cycles with `a_valid`=0.
  - `stall_cnt` clears on `start` acceptance and on reset.
  - It holds its value after the job ends.
- **Undefined:** the port and the counter do not exist. All other behaviour is identical.

## Test plan
- **Identity weights:** N=4, W=identity, `num_vec`=1, a=[1,2,3,4] → `r_valid` 8 cycles after acceptance, R=[1,2,3,4], `done` on the next cycle.
- **Signed extremes:** all W=−128, a=[255,255,255,255] → every R[j]=−130560. With all W=127 → R[j]=129540.
- **Gapped stream:** `num_vec`=3, `a_valid` pattern 1,0,1,1, W row i=[i+1,0,0,0] → three `r_valid` with the same 1,0,1,1 gaps and correct per-vector sums. `stall_cnt`=1 when `SYSTOLIC_CTRL_PERF_EN` is defined.
- **Empty job:** `num_vec`=0 → 4 weight beats accepted, `a_ready` never high, no `r_valid`, `done` 1 cycle after the last weight beat.
- **Reset mid-STREAM:** `reset_n` low for 1 cycle after 2 of 5 vectors → next cycle all outputs 0 and no late `r_valid`. A new job then completes correctly.
- **Ignored inputs:**
  - `start` pulsed while busy → ignored.
  - `w_valid` held during STREAM → weights unchanged.
  - Results match the first job's weights.
